// File: rtl/band_energy_detect.sv
// band_energy_detect
//   Mean-magnitude energy detector with hysteresis for a bandpass filter output.
//   Each window of 2^WINDOW_LOG2 valid samples is averaged into energy_out.
//   A four-state detector then needs HOLD_WINDOWS consecutive qualifying
//   windows before it asserts or releases tone_detected.
//
// Parameters
//   SIG_WIDTH    : unsigned upstream sample width; the filtered sample is SIG_WIDTH+1 bits signed
//   WINDOW_LOG2  : log2 of the number of samples per averaging window
//   HOLD_WINDOWS : consecutive qualifying windows needed to change state (1..15)
//
// Ports
//   clk_in        : clock; all logic runs on its rising edge
//   rst_in        : asynchronous active-high reset
//   y_in          : signed filter output sample
//   y_in_valid    : one-cycle strobe qualifying y_in
//   flush_in      : synchronous restart of the current window (the sample in that cycle is dropped)
//   thresh_on     : assert threshold (energy_out >= thresh_on qualifies)
//   thresh_off    : release threshold (energy_out < thresh_off qualifies)
//   energy_out    : mean magnitude of the last completed window
//   energy_valid  : one-cycle pulse when energy_out updates
//   tone_detected : registered detect flag
module band_energy_detect #(
    parameter int SIG_WIDTH    = 8,
    parameter int WINDOW_LOG2  = 8,
    parameter int HOLD_WINDOWS = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic signed [SIG_WIDTH:0]   y_in,
    input  logic                        y_in_valid,
    input  logic                        flush_in,
    input  logic        [SIG_WIDTH:0]   thresh_on,
    input  logic        [SIG_WIDTH:0]   thresh_off,
    output logic        [SIG_WIDTH:0]   energy_out,
    output logic                        energy_valid,
    output logic                        tone_detected
);

    localparam int MAG_W = SIG_WIDTH + 1;
    localparam int ACC_W = MAG_W + WINDOW_LOG2;
    localparam logic [3:0] HOLD_N = 4'(HOLD_WINDOWS);

    typedef enum logic [1:0] {QUIET, ARMING, DETECTED, RELEASING} state_t;

    // Two's-complement magnitude computed in the unsigned domain, so the most
    // negative input (100..0) maps to 2^SIG_WIDTH, which still fits MAG_W bits.
    function automatic logic [MAG_W-1:0] abs_mag(input logic signed [MAG_W-1:0] x);
        logic [MAG_W-1:0] u;
        u = $unsigned(x);
        abs_mag = u[MAG_W-1] ? (~u + MAG_W'(1)) : u;
    endfunction

    // Truncating divide by the window length: keep the top MAG_W bits of the sum.
    function automatic logic [MAG_W-1:0] window_mean(input logic [ACC_W-1:0] sum);
        window_mean = sum[ACC_W-1:WINDOW_LOG2];
    endfunction

    logic [MAG_W-1:0]       mag_p0;
    logic [ACC_W-1:0]       acc_p0;
    logic [ACC_W-1:0]       sum_p0;
    logic [WINDOW_LOG2-1:0] cnt_p0;
    logic                   last_p0;

    assign mag_p0  = abs_mag(y_in);
    assign sum_p0  = acc_p0 + {{WINDOW_LOG2{1'b0}}, mag_p0};
    assign last_p0 = (cnt_p0 == '1);

    // ---- stage p0 -> p1: accumulate; the completing sample is folded in and
    //      the accumulator restarts at zero so the next strobe is sample 0.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc_p0       <= '0;
            cnt_p0       <= '0;
            energy_out   <= '0;
            energy_valid <= 1'b0;
        end else begin
            energy_valid <= 1'b0;
            if (flush_in) begin
                acc_p0 <= '0;
                cnt_p0 <= '0;
            end else if (y_in_valid) begin
                if (last_p0) begin
                    acc_p0       <= '0;
                    cnt_p0       <= '0;
                    energy_out   <= window_mean(sum_p0);
                    energy_valid <= 1'b1;
                end else begin
                    acc_p0 <= sum_p0;
                    cnt_p0 <= cnt_p0 + WINDOW_LOG2'(1);
                end
            end
        end
    end

    state_t     state_q, state_d;
    logic [3:0] hold_q, hold_d, hold_inc;
    logic       above_on, below_off;

    // Only thresh_on matters while quiet/arming and only thresh_off while
    // detected/releasing, so any ordering of the two thresholds is consistent.
    assign above_on  = (energy_out >= thresh_on);
    assign below_off = (energy_out <  thresh_off);
    assign hold_inc  = hold_q + 4'd1;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (energy_valid) begin
            case (state_q)
                QUIET: begin
                    if (above_on) begin
                        if (HOLD_N == 4'd1) begin
                            state_d = DETECTED;
                            hold_d  = 4'd0;
                        end else begin
                            state_d = ARMING;
                            hold_d  = 4'd1;
                        end
                    end
                end
                ARMING: begin
                    if (!above_on) begin
                        state_d = QUIET;
                        hold_d  = 4'd0;
                    end else if (hold_inc == HOLD_N) begin
                        state_d = DETECTED;
                        hold_d  = 4'd0;
                    end else begin
                        hold_d  = hold_inc;
                    end
                end
                DETECTED: begin
                    if (below_off) begin
                        if (HOLD_N == 4'd1) begin
                            state_d = QUIET;
                            hold_d  = 4'd0;
                        end else begin
                            state_d = RELEASING;
                            hold_d  = 4'd1;
                        end
                    end
                end
                RELEASING: begin
                    if (!below_off) begin
                        state_d = DETECTED;
                        hold_d  = 4'd0;
                    end else if (hold_inc == HOLD_N) begin
                        state_d = QUIET;
                        hold_d  = 4'd0;
                    end else begin
                        hold_d  = hold_inc;
                    end
                end
                default: begin
                    state_d = QUIET;
                    hold_d  = 4'd0;
                end
            endcase
        end
    end

    // ---- stage p1 -> p2: detector state; tone_detected is registered from the
    //      next state so it lands two cycles after the completing sample.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= QUIET;
            hold_q        <= 4'd0;
            tone_detected <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            tone_detected <= (state_d == DETECTED) || (state_d == RELEASING);
        end
    end

endmodule

// File: tb/tb_band_energy_detect.sv
// tb_band_energy_detect
//   Directed bench for band_energy_detect with WINDOW_LOG2=4, HOLD_WINDOWS=2,
//   thresh_on=50, thresh_off=30. A window-level behavioural model (sample sum,
//   run length of qualifying windows) is compared against the DUT every cycle;
//   hand-computed literals pin each window's mean and detect flag.
module tb_band_energy_detect;

    localparam int SW = 8;
    localparam int YW = SW + 1;
    localparam int WL = 4;
    localparam int HW = 2;
    localparam int N  = 16;

    logic                 clk_in = 1'b0;
    logic                 rst_in = 1'b1;
    logic signed [SW:0]   y_in = '0;
    logic                 y_in_valid = 1'b0;
    logic                 flush_in = 1'b0;
    logic        [SW:0]   thresh_on = YW'(50);
    logic        [SW:0]   thresh_off = YW'(30);
    logic        [SW:0]   energy_out;
    logic                 energy_valid;
    logic                 tone_detected;

    int checks = 0;
    int errors = 0;

    band_energy_detect #(
        .SIG_WIDTH   (SW),
        .WINDOW_LOG2 (WL),
        .HOLD_WINDOWS(HW)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .y_in         (y_in),
        .y_in_valid   (y_in_valid),
        .flush_in     (flush_in),
        .thresh_on    (thresh_on),
        .thresh_off   (thresh_off),
        .energy_out   (energy_out),
        .energy_valid (energy_valid),
        .tone_detected(tone_detected)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: a window is a running sum of magnitudes; its mean is
    // published the cycle after the 16th sample. Detection counts how many
    // consecutive windows qualified against the threshold relevant to the
    // current flag and flips the flag once that run reaches HW.
    int m_sum = 0, m_cnt = 0, m_energy = 0, m_run = 0;
    bit m_ev = 1'b0, m_det = 1'b0;

    always @(posedge clk_in or posedge rst_in) begin
        int mag, s, c, e, run;
        bit ev, det;
        if (rst_in) begin
            m_sum    <= 0;
            m_cnt    <= 0;
            m_energy <= 0;
            m_run    <= 0;
            m_ev     <= 1'b0;
            m_det    <= 1'b0;
        end else begin
            det = m_det;
            run = m_run;
            if (m_ev) begin
                if (!det) begin
                    run = (m_energy >= int'(thresh_on)) ? run + 1 : 0;
                    if (run == HW) begin det = 1'b1; run = 0; end
                end else begin
                    run = (m_energy < int'(thresh_off)) ? run + 1 : 0;
                    if (run == HW) begin det = 1'b0; run = 0; end
                end
            end
            s  = m_sum;
            c  = m_cnt;
            e  = m_energy;
            ev = 1'b0;
            if (flush_in) begin
                s = 0;
                c = 0;
            end else if (y_in_valid) begin
                mag = (int'(y_in) < 0) ? -int'(y_in) : int'(y_in);
                s = s + mag;
                c = c + 1;
                if (c == N) begin
                    e  = s / N;
                    ev = 1'b1;
                    s  = 0;
                    c  = 0;
                end
            end
            m_sum    <= s;
            m_cnt    <= c;
            m_energy <= e;
            m_ev     <= ev;
            m_run    <= run;
            m_det    <= det;
        end
    end

    always @(negedge clk_in) begin
        chk("cycle energy_valid", int'(energy_valid), int'(m_ev));
        chk("cycle energy_out", int'(energy_out), m_energy);
        chk("cycle tone_detected", int'(tone_detected), int'(m_det));
    end

    task automatic send(input int val, input int n, input bit alt);
        for (int i = 0; i < n; i++) begin
            y_in       = (alt && (i % 2 == 1)) ? YW'(-val) : YW'(val);
            y_in_valid = 1'b1;
            @(negedge clk_in);
        end
        y_in_valid = 1'b0;
        y_in       = '0;
    endtask

    // One full window, then literal checks: pulse present one cycle after the
    // 16th strobe, mean value, pulse gone next cycle, flag before and after.
    task automatic window(input string tag, input int val, input bit alt,
                          input int e_lit, input bit t_before, input bit t_after);
        send(val, N, alt);
        chk({tag, " energy_valid pulse"}, int'(energy_valid), 1);
        chk({tag, " energy_out"}, int'(energy_out), e_lit);
        chk({tag, " tone at pulse"}, int'(tone_detected), int'(t_before));
        @(negedge clk_in);
        chk({tag, " energy_valid single"}, int'(energy_valid), 0);
        chk({tag, " tone after"}, int'(tone_detected), int'(t_after));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk_in);
        chk("reset energy_out", int'(energy_out), 0);
        chk("reset energy_valid", int'(energy_valid), 0);
        chk("reset tone", int'(tone_detected), 0);
        rst_in = 1'b0;
        @(negedge clk_in);

        window("dc100", 100, 1'b0, 100, 1'b0, 1'b0);
        window("alt100", 100, 1'b1, 100, 1'b0, 1'b1);
        window("neg256", -256, 1'b0, 256, 1'b1, 1'b1);
        window("rel20a", 20, 1'b0, 20, 1'b1, 1'b1);
        window("rel20b", 20, 1'b0, 20, 1'b1, 1'b0);

        window("m60a", 60, 1'b0, 60, 1'b0, 1'b0);
        window("m40", 40, 1'b0, 40, 1'b0, 1'b0);
        window("m60b", 60, 1'b0, 60, 1'b0, 1'b0);
        window("m20", 20, 1'b0, 20, 1'b0, 1'b0);
        window("on60a", 60, 1'b0, 60, 1'b0, 1'b0);
        window("on60b", 60, 1'b0, 60, 1'b0, 1'b1);

        window("off20a", 20, 1'b0, 20, 1'b1, 1'b1);
        window("off40", 40, 1'b0, 40, 1'b1, 1'b1);
        window("off20b", 20, 1'b0, 20, 1'b1, 1'b1);
        window("off20c", 20, 1'b0, 20, 1'b1, 1'b0);

        send(50, 10, 1'b0);
        y_in       = YW'(77);
        y_in_valid = 1'b1;
        flush_in   = 1'b1;
        @(negedge clk_in);
        flush_in   = 1'b0;
        y_in_valid = 1'b0;
        chk("flush no pulse", int'(energy_valid), 0);
        window("flush80", 80, 1'b0, 80, 1'b0, 1'b0);

        window("edge50", 50, 1'b0, 50, 1'b0, 1'b1);
        window("edge30", 30, 1'b0, 30, 1'b1, 1'b1);

        send(70, 7, 1'b0);
        #2 rst_in = 1'b1;
        #1;
        chk("async rst energy_out", int'(energy_out), 0);
        chk("async rst energy_valid", int'(energy_valid), 0);
        chk("async rst tone", int'(tone_detected), 0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        window("post_rst70", 70, 1'b0, 70, 1'b0, 1'b0);

        repeat (2) @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
